// File: rtl/rv_regfile_scoreboard_if.sv
// Register file bundle: operand reads, destination
// reservation, writeback ports, flush and busy count.
interface rv_regfile_scoreboard_if #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int NRD  = 2,
  parameter int NWB  = 2
);
  localparam int AW = $clog2(NREG);

  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_avail;
  logic                rsv_valid;
  logic [AW-1:0]       rsv_addr;
  logic                rsv_ok;
  logic [NWB-1:0]      wb_en;
  logic [NWB*AW-1:0]   wb_addr;
  logic [NWB*XLEN-1:0] wb_data;
  logic                flush;
  logic [AW:0]         busy_count;

  modport master (
    output rd_addr,
    input  rd_data,
    input  rd_avail,
    output rsv_valid,
    output rsv_addr,
    input  rsv_ok,
    output wb_en,
    output wb_addr,
    output wb_data,
    output flush,
    input  busy_count
  );

  modport slave (
    input  rd_addr,
    output rd_data,
    output rd_avail,
    input  rsv_valid,
    input  rsv_addr,
    output rsv_ok,
    input  wb_en,
    input  wb_addr,
    input  wb_data,
    input  flush,
    output busy_count
  );
endinterface

// File: rtl/rv_regfile_scoreboard.sv
// Integer register file with per-register busy
// scoreboard, multi-port writeback and bypass.
module rv_regfile_scoreboard #(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int NRD    = 2,
  parameter int NWB    = 2,
  parameter bit BYPASS = 1'b1
) (
  input logic clk,
  input logic rst,
  rv_regfile_scoreboard_if.slave bus
);
  localparam int AW = $clog2(NREG);

  logic [XLEN-1:0] regs [NREG];
  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_nxt;
  logic [NREG-1:0] wb_hit;
  logic [AW:0]     count;
  logic [AW:0]     count_nxt;
  logic            rsv_ok;

  logic [AW-1:0]   ra [NRD];
  logic [AW-1:0]   wa [NWB];
  logic [XLEN-1:0] wd [NWB];

  for (genvar i = 0; i < NRD; i++) begin : g_ra
    assign ra[i] = bus.rd_addr[i*AW +: AW];
  end

  for (genvar j = 0; j < NWB; j++) begin : g_wb
    assign wa[j] = bus.wb_addr[j*AW +: AW];
    assign wd[j] = bus.wb_data[j*XLEN +: XLEN];
  end

  // Registers targeted by any enabled writeback port
  always_comb begin
    wb_hit = '0;
    for (int j = 0; j < NWB; j++)
      if (bus.wb_en[j])
        wb_hit[wa[j]] = 1'b1;
  end

  // Operand reads; later wb ports override earlier
  always_comb begin
    bus.rd_data  = '0;
    bus.rd_avail = '0;
    for (int i = 0; i < NRD; i++) begin
      if (ra[i] == '0) begin
        bus.rd_avail[i] = 1'b1;
      end else begin
        bus.rd_data[i*XLEN +: XLEN] = regs[ra[i]];
        bus.rd_avail[i] = !busy[ra[i]];
        if (BYPASS) begin
          for (int j = 0; j < NWB; j++) begin
            if (bus.wb_en[j] && wa[j] == ra[i]) begin
              bus.rd_data[i*XLEN +: XLEN] = wd[j];
              bus.rd_avail[i] = 1'b1;
            end
          end
        end
      end
    end
  end

  // A reservation clears when the target frees this cycle
  assign rsv_ok = bus.rsv_valid && !bus.flush &&
                  (bus.rsv_addr == '0 ||
                   !busy[bus.rsv_addr] ||
                   wb_hit[bus.rsv_addr]);

  assign bus.rsv_ok     = rsv_ok;
  assign bus.busy_count = count;

  // Next busy vector: reserve beats writeback, x0 never busy
  always_comb begin
    busy_nxt = busy & ~wb_hit;
    if (bus.flush)
      busy_nxt = '0;
    if (rsv_ok)
      busy_nxt[bus.rsv_addr] = 1'b1;
    busy_nxt[0] = 1'b0;
    count_nxt = '0;
    for (int k = 0; k < NREG; k++)
      count_nxt = count_nxt + {{AW{1'b0}}, busy_nxt[k]};
  end

  // State update; highest-index wb port wins on collision
  always_ff @(posedge clk) begin
    if (rst) begin
      busy  <= '0;
      count <= '0;
      for (int k = 0; k < NREG; k++)
        regs[k] <= '0;
    end else begin
      busy  <= busy_nxt;
      count <= count_nxt;
      for (int j = 0; j < NWB; j++)
        if (bus.wb_en[j] && wa[j] != '0)
          regs[wa[j]] <= wd[j];
    end
  end
endmodule

// File: tb/tb_rv_regfile_scoreboard.sv
// Scoreboard-driven bench for rv_regfile_scoreboard:
// expected reads queued with stimulus, drained each cycle.
module tb_rv_regfile_scoreboard;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int errors = 0;
  int checks = 0;

  typedef struct {
    int          port;
    logic [31:0] data;
    logic        avail;
    string       tag;
  } exp_t;

  exp_t sb [$];

  rv_regfile_scoreboard_if #(
    .XLEN(32), .NREG(32), .NRD(2), .NWB(2)
  ) bus ();

  rv_regfile_scoreboard #(
    .XLEN(32), .NREG(32), .NRD(2), .NWB(2),
    .BYPASS(1'b1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.rsv_valid = 1'b0;
    bus.rsv_addr  = '0;
    bus.wb_en     = '0;
    bus.flush     = 1'b0;
  endtask

  task automatic drv_rd(input int p, input logic [4:0] a,
                        input logic [31:0] d, input logic v,
                        input string tag);
    bus.rd_addr[p*5 +: 5] = a;
    sb.push_back('{port: p, data: d, avail: v, tag: tag});
  endtask

  task automatic drv_wb(input int p, input logic [4:0] a,
                        input logic [31:0] d);
    bus.wb_en[p] = 1'b1;
    bus.wb_addr[p*5 +: 5] = a;
    bus.wb_data[p*32 +: 32] = d;
  endtask

  task automatic test_reset();
    exp_t e;
    checks++;
    if (bus.busy_count !== 6'd0) begin
      errors++;
      $display("FAIL rst_count: got %0d want 0", bus.busy_count);
    end
    bus.rsv_valid = 1'b1;
    bus.rsv_addr  = 5'd3;
    bus.flush     = 1'b1;
    #1;
    checks++;
    if (bus.rsv_ok !== 1'b0) begin
      errors++;
      $display("FAIL rst_rsv_flush: got %b want 0", bus.rsv_ok);
    end
    bus.flush = 1'b0;
    #1;
    checks++;
    if (bus.rsv_ok !== 1'b1) begin
      errors++;
      $display("FAIL rst_rsv_ok: got %b want 1", bus.rsv_ok);
    end
    idle();
    tick();
    for (int a = 0; a < 32; a++) begin
      drv_rd(0, 5'(a), 32'h0, 1'b1, "rst_p0");
      drv_rd(1, 5'(31 - a), 32'h0, 1'b1, "rst_p1");
      #1;
      while (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if ({bus.rd_data[e.port*32 +: 32], bus.rd_avail[e.port]}
            !== {e.data, e.avail}) begin
          errors++;
          $display("FAIL %s: got %h/%b want %h/%b", e.tag,
                   bus.rd_data[e.port*32 +: 32],
                   bus.rd_avail[e.port], e.data, e.avail);
        end
      end
      tick();
    end
  endtask

  task automatic test_reserve_wb();
    exp_t e;
    idle();
    bus.rsv_valid = 1'b1;
    bus.rsv_addr  = 5'd5;
    #1;
    checks++;
    if (bus.rsv_ok !== 1'b1) begin
      errors++;
      $display("FAIL rsv_x5: got %b want 1", bus.rsv_ok);
    end
    tick();
    idle();
    drv_rd(0, 5'd5, 32'h0, 1'b0, "x5_busy");
    #1;
    checks++;
    if (bus.busy_count !== 6'd1) begin
      errors++;
      $display("FAIL cnt_x5: got %0d want 1", bus.busy_count);
    end
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if ({bus.rd_data[e.port*32 +: 32], bus.rd_avail[e.port]}
          !== {e.data, e.avail}) begin
        errors++;
        $display("FAIL %s: got %h/%b want %h/%b", e.tag,
                 bus.rd_data[e.port*32 +: 32],
                 bus.rd_avail[e.port], e.data, e.avail);
      end
    end
    tick();
    drv_wb(0, 5'd5, 32'hDEADBEEF);
    drv_rd(0, 5'd5, 32'hDEADBEEF, 1'b1, "x5_byp0");
    drv_rd(1, 5'd5, 32'hDEADBEEF, 1'b1, "x5_byp1");
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if ({bus.rd_data[e.port*32 +: 32], bus.rd_avail[e.port]}
          !== {e.data, e.avail}) begin
        errors++;
        $display("FAIL %s: got %h/%b want %h/%b", e.tag,
                 bus.rd_data[e.port*32 +: 32],
                 bus.rd_avail[e.port], e.data, e.avail);
      end
    end
    tick();
    idle();
    drv_rd(0, 5'd5, 32'hDEADBEEF, 1'b1, "x5_final");
    #1;
    checks++;
    if (bus.busy_count !== 6'd0) begin
      errors++;
      $display("FAIL cnt_x5_clr: got %0d want 0", bus.busy_count);
    end
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if ({bus.rd_data[e.port*32 +: 32], bus.rd_avail[e.port]}
          !== {e.data, e.avail}) begin
        errors++;
        $display("FAIL %s: got %h/%b want %h/%b", e.tag,
                 bus.rd_data[e.port*32 +: 32],
                 bus.rd_avail[e.port], e.data, e.avail);
      end
    end
    tick();
  endtask

  task automatic test_waw();
    exp_t e;
    idle();
    bus.rsv_valid = 1'b1;
    bus.rsv_addr  = 5'd5;
    tick();
    #1;
    checks++;
    if (bus.rsv_ok !== 1'b0) begin
      errors++;
      $display("FAIL waw_stall: got %b want 0", bus.rsv_ok);
    end
    tick();
    drv_wb(1, 5'd5, 32'h12345678);
    drv_rd(0, 5'd5, 32'h12345678, 1'b1, "waw_byp");
    #1;
    checks++;
    if (bus.rsv_ok !== 1'b1) begin
      errors++;
      $display("FAIL waw_wb_ok: got %b want 1", bus.rsv_ok);
    end
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if ({bus.rd_data[e.port*32 +: 32], bus.rd_avail[e.port]}
          !== {e.data, e.avail}) begin
        errors++;
        $display("FAIL %s: got %h/%b want %h/%b", e.tag,
                 bus.rd_data[e.port*32 +: 32],
                 bus.rd_avail[e.port], e.data, e.avail);
      end
    end
    tick();
    idle();
    drv_rd(0, 5'd5, 32'h12345678, 1'b0, "waw_still_busy");
    #1;
    checks++;
    if (bus.busy_count !== 6'd1) begin
      errors++;
      $display("FAIL waw_cnt: got %0d want 1", bus.busy_count);
    end
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if ({bus.rd_data[e.port*32 +: 32], bus.rd_avail[e.port]}
          !== {e.data, e.avail}) begin
        errors++;
        $display("FAIL %s: got %h/%b want %h/%b", e.tag,
                 bus.rd_data[e.port*32 +: 32],
                 bus.rd_avail[e.port], e.data, e.avail);
      end
    end
    drv_wb(0, 5'd5, 32'h12345678);
    tick();
    idle();
    #1;
    checks++;
    if (bus.busy_count !== 6'd0) begin
      errors++;
      $display("FAIL waw_cnt_clr: got %0d want 0", bus.busy_count);
    end
    tick();
  endtask

  task automatic test_multi_wb();
    exp_t e;
    idle();
    drv_wb(0, 5'd7, 32'h11);
    drv_wb(1, 5'd7, 32'h22);
    drv_rd(0, 5'd7, 32'h22, 1'b1, "x7_byp");
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if ({bus.rd_data[e.port*32 +: 32], bus.rd_avail[e.port]}
          !== {e.data, e.avail}) begin
        errors++;
        $display("FAIL %s: got %h/%b want %h/%b", e.tag,
                 bus.rd_data[e.port*32 +: 32],
                 bus.rd_avail[e.port], e.data, e.avail);
      end
    end
    tick();
    idle();
    drv_rd(1, 5'd7, 32'h22, 1'b1, "x7_array");
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if ({bus.rd_data[e.port*32 +: 32], bus.rd_avail[e.port]}
          !== {e.data, e.avail}) begin
        errors++;
        $display("FAIL %s: got %h/%b want %h/%b", e.tag,
                 bus.rd_data[e.port*32 +: 32],
                 bus.rd_avail[e.port], e.data, e.avail);
      end
    end
    tick();
  endtask

  task automatic test_flush();
    exp_t e;
    for (int r = 1; r <= 3; r++) begin
      idle();
      bus.rsv_valid = 1'b1;
      bus.rsv_addr  = 5'(r);
      tick();
      idle();
      #1;
      checks++;
      if (bus.busy_count !== 6'(r)) begin
        errors++;
        $display("FAIL flush_fill: got %0d want %0d",
                 bus.busy_count, r);
      end
    end
    bus.flush     = 1'b1;
    bus.rsv_valid = 1'b1;
    bus.rsv_addr  = 5'd4;
    drv_wb(0, 5'd9, 32'h55);
    #1;
    checks++;
    if (bus.rsv_ok !== 1'b0) begin
      errors++;
      $display("FAIL flush_rsv: got %b want 0", bus.rsv_ok);
    end
    tick();
    idle();
    drv_rd(0, 5'd4, 32'h0, 1'b1, "flush_x4");
    drv_rd(1, 5'd9, 32'h55, 1'b1, "flush_x9");
    #1;
    checks++;
    if (bus.busy_count !== 6'd0) begin
      errors++;
      $display("FAIL flush_cnt: got %0d want 0", bus.busy_count);
    end
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if ({bus.rd_data[e.port*32 +: 32], bus.rd_avail[e.port]}
          !== {e.data, e.avail}) begin
        errors++;
        $display("FAIL %s: got %h/%b want %h/%b", e.tag,
                 bus.rd_data[e.port*32 +: 32],
                 bus.rd_avail[e.port], e.data, e.avail);
      end
    end
    tick();
  endtask

  task automatic test_x0();
    exp_t e;
    idle();
    drv_wb(0, 5'd0, 32'hFFFFFFFF);
    bus.rsv_valid = 1'b1;
    bus.rsv_addr  = 5'd0;
    drv_rd(0, 5'd0, 32'h0, 1'b1, "x0_same_p0");
    drv_rd(1, 5'd0, 32'h0, 1'b1, "x0_same_p1");
    #1;
    checks++;
    if (bus.rsv_ok !== 1'b1) begin
      errors++;
      $display("FAIL x0_rsv_ok: got %b want 1", bus.rsv_ok);
    end
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if ({bus.rd_data[e.port*32 +: 32], bus.rd_avail[e.port]}
          !== {e.data, e.avail}) begin
        errors++;
        $display("FAIL %s: got %h/%b want %h/%b", e.tag,
                 bus.rd_data[e.port*32 +: 32],
                 bus.rd_avail[e.port], e.data, e.avail);
      end
    end
    tick();
    idle();
    drv_rd(0, 5'd0, 32'h0, 1'b1, "x0_next");
    #1;
    checks++;
    if (bus.busy_count !== 6'd0) begin
      errors++;
      $display("FAIL x0_cnt: got %0d want 0", bus.busy_count);
    end
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if ({bus.rd_data[e.port*32 +: 32], bus.rd_avail[e.port]}
          !== {e.data, e.avail}) begin
        errors++;
        $display("FAIL %s: got %h/%b want %h/%b", e.tag,
                 bus.rd_data[e.port*32 +: 32],
                 bus.rd_avail[e.port], e.data, e.avail);
      end
    end
    tick();
  endtask

  task automatic test_back_to_back();
    exp_t e;
    idle();
    bus.rsv_valid = 1'b1;
    bus.rsv_addr  = 5'd10;
    tick();
    bus.rsv_addr = 5'd11;
    drv_wb(1, 5'd10, 32'hA0);
    #1;
    checks++;
    if (bus.rsv_ok !== 1'b1 || bus.busy_count !== 6'd1) begin
      errors++;
      $display("FAIL b2b_rsv: got ok=%b cnt=%0d want 1/1",
               bus.rsv_ok, bus.busy_count);
    end
    tick();
    idle();
    drv_wb(0, 5'd11, 32'hB1);
    drv_rd(0, 5'd10, 32'hA0, 1'b1, "b2b_x10");
    drv_rd(1, 5'd11, 32'hB1, 1'b1, "b2b_x11_byp");
    #1;
    checks++;
    if (bus.busy_count !== 6'd1) begin
      errors++;
      $display("FAIL b2b_cnt: got %0d want 1", bus.busy_count);
    end
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if ({bus.rd_data[e.port*32 +: 32], bus.rd_avail[e.port]}
          !== {e.data, e.avail}) begin
        errors++;
        $display("FAIL %s: got %h/%b want %h/%b", e.tag,
                 bus.rd_data[e.port*32 +: 32],
                 bus.rd_avail[e.port], e.data, e.avail);
      end
    end
    tick();
    idle();
    drv_rd(1, 5'd11, 32'hB1, 1'b1, "b2b_x11");
    #1;
    checks++;
    if (bus.busy_count !== 6'd0) begin
      errors++;
      $display("FAIL b2b_cnt_clr: got %0d want 0", bus.busy_count);
    end
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if ({bus.rd_data[e.port*32 +: 32], bus.rd_avail[e.port]}
          !== {e.data, e.avail}) begin
        errors++;
        $display("FAIL %s: got %h/%b want %h/%b", e.tag,
                 bus.rd_data[e.port*32 +: 32],
                 bus.rd_avail[e.port], e.data, e.avail);
      end
    end
    tick();
  endtask

  initial begin
    idle();
    bus.rd_addr = '0;
    bus.wb_addr = '0;
    bus.wb_data = '0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    test_reset();
    test_reserve_wb();
    test_waw();
    test_multi_wb();
    test_flush();
    test_x0();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/rv_regfile_scoreboard.md
# rv_regfile_scoreboard

Parametrised integer register file with per-register busy scoreboard for the RV32 core. Generalises the single-write register port and its `RegReadPortType.isRegAvailable` flag to NRD read ports, NWB writeback ports, optional same-cycle bypass and a flush that cancels all outstanding reservations. Sits between decode/issue, which reads operands and reserves destinations, and the execute/LSU writeback paths.

## Interface
- XLEN, 32, register data width (matches `OperandType`).
- NREG, 32, number of architectural registers; AW = $clog2(NREG), 5 at default.
- NRD, 2, number of read ports.
- NWB, 2, number of writeback ports.
- BYPASS, 1, 1 = writeback data forwarded combinationally to same-cycle reads.

- clk  in  1  clock; single clock domain, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- rd_addr  in  NRD*AW  read addresses, port i at [i*AW +: AW].
- rd_data  out  NRD*XLEN  read data per port (combinational).
- rd_avail  out  NRD  1 = value in rd_data is final (register not busy, or bypassed).
- rsv_valid  in  1  issue requests reservation of destination rsv_addr.
- rsv_addr  in  AW  destination register to reserve.
- rsv_ok  out  1  reservation accepted this cycle (combinational).
- wb_en  in  NWB  writeback enable per port.
- wb_addr  in  NWB*AW  writeback addresses.
- wb_data  in  NWB*XLEN  writeback data.
- flush  in  1  clear all busy bits (branch mispredict recovery).
- busy_count  out  AW+1  registered count of currently busy registers.

## Operation
- State: data array reg[NREG], busy vector busy[NREG], busy_count register.
- x0: reads return 0, rd_avail=1; never busy; writes and reservations to x0 discarded (rsv_ok=1 for x0, no effect).
- Read port i: if BYPASS and any wb_en[j] with wb_addr[j]==rd_addr[i]!=0 -> rd_data = wb_data[j], rd_avail=1; else rd_data = reg[rd_addr[i]], rd_avail = !busy[rd_addr[i]].
- Multiple writebacks to same address in one cycle: highest-index port wins for both array write and bypass.
- Writeback: array updated at next edge; busy bit of wb_addr cleared. Writeback to a non-busy register still writes data (squash of stale results is upstream's job).
- Reservation: rsv_ok = rsv_valid && !flush && (rsv_addr==0 || !busy[rsv_addr] || a wb_en targets rsv_addr this cycle). On rsv_ok, busy[rsv_addr] set at next edge. WAW on a busy register without clearing writeback -> rsv_ok=0; issue stalls.
- Reserve and writeback to same register same cycle: reserve wins, busy stays 1, data still written.
- Flush: all busy bits cleared at next edge; concurrent reservation dropped (rsv_ok=0); concurrent writebacks still write data.
- busy_count: popcount of next-state busy vector, registered; range 0..NREG-1.

## Timing
- Reset (rst=1 at edge): all reg = 0, busy = 0, busy_count = 0. Outputs after reset: rd_data=0, rd_avail=all 1, rsv_ok=rsv_valid && !flush.
- Reset dominates flush, rsv_valid and wb_en in the same cycle.
- Read latency: 0 cycles (combinational from rd_addr, wb_*, busy).
- Write latency: array visible to non-bypassed reads 1 cycle after wb_en; visible same cycle when BYPASS=1.
- Busy set/clear and busy_count take effect 1 cycle after the causing event.
- rsv_ok depends combinationally on rsv_valid, rsv_addr, flush, wb_en, wb_addr, busy; no path from rd_addr.

## Test plan
- Reset then read x0..x31 on both ports -> all rd_data=0, rd_avail=1, busy_count=0.
- Reserve x5 cycle 0; cycle 1 read x5 -> rd_avail=0; cycle 2 wb x5=0xDEADBEEF -> same-cycle read returns 0xDEADBEEF, rd_avail=1 (BYPASS=1), busy_count 1->0 next cycle.
- x5 busy; reserve x5 without writeback -> rsv_ok=0; reserve x5 while wb x5 same cycle -> rsv_ok=1, x5 remains busy, data written.
- wb port0 x7=0x11, port1 x7=0x22 same cycle -> next-cycle read x7=0x22.
- Reserve x1,x2,x3 over 3 cycles (busy_count=3); flush with rsv x4 and wb x9=0x55 -> busy_count=0, x4 not busy, x9=0x55.
- Write x0=0xFFFFFFFF and reserve x0 -> reads of x0 return 0, rd_avail=1, busy_count unchanged.
